icap_ctl: RTL and testbench

Downstream stage of the system controller's ICAP register: buffers the 18-bit command words the CPU writes through sysctl and replays each one to the FPGA configuration port (ICAP) with a generated, slower ICAP clock. It performs the per-byte bit reversal that the configuration port requires, so software writes configuration words in natural order. It sits between sysctl and the ICAP primitive instance at the SoC top level.

---
 rtl/icap_pkg.sv | 26 ++
 rtl/icap_fifo.sv | 58 +++++
 rtl/icap_ctl.sv | 142 ++++++++++++++
 tb/tb_icap_ctl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_pkg.sv
// Shared definitions for the ICAP command path: command word field positions,
// FSM state encoding and the per-byte bit reversal the configuration port expects.
package icap_pkg;

    localparam int ICAP_DATA_MSB = 15;
    localparam int ICAP_CE_BIT   = 16;
    localparam int ICAP_WR_BIT   = 17;
    localparam int ICAP_CMD_W    = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2
    } icap_state_e;

    // Bit i of each byte moves to bit 7-i; byte order is preserved.
    function automatic logic [15:0] bitswap16(input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = d[7-i];
            r[8+i]   = d[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_fifo.sv
// DEPTH-entry synchronous command FIFO; pushes while full are ignored and the
// caller is expected to pop only when count is non-zero.
module icap_fifo
    import icap_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ICAP_CMD_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          full
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/icap_ctl.sv
// Buffers sysctl ICAP command words and replays each one to the configuration
// port with a generated icap_clk of period 2*CLKDIV sys_clk cycles.
module icap_ctl
    import icap_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CLKDIV = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_stb,
    input  logic [17:0] cmd_data,
    output logic        cmd_ready,
    output logic        busy,
    input  logic        ovf_clr,
    output logic        overflow,
    output logic        icap_clk,
    output logic        icap_ce_n,
    output logic        icap_write_n,
    output logic [15:0] icap_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKDIV) + 1;

    icap_state_e state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic          clk_q, clk_d;
    logic          ce_n_q, ce_n_d;
    logic          wr_n_q, wr_n_d;
    logic [15:0]   data_q, data_d;
    logic          ovf_q, ovf_d;

    logic [17:0]   head;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          load;
    logic          div_last;

    icap_fifo #(.DEPTH(DEPTH), .W(ICAP_CMD_W)) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (cmd_stb),
        .pop   (pop),
        .wdata (cmd_data),
        .head  (head),
        .count (count),
        .full  (full)
    );

    assign empty    = (count == '0);
    assign div_last = (div_q == CW'(CLKDIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        clk_d   = clk_q;
        ce_n_d  = ce_n_q;
        wr_n_d  = wr_n_q;
        data_d  = data_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    div_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_last) begin
                    clk_d   = 1'b1;
                    div_d   = '0;
                    state_d = ST_HIGH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (div_last) begin
                    // Falling edge doubles as the load edge of the next word: no idle gap.
                    clk_d = 1'b0;
                    div_d = '0;
                    if (!empty) begin
                        load    = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            pop    = 1'b1;
            ce_n_d = head[ICAP_CE_BIT];
            wr_n_d = head[ICAP_WR_BIT];
            data_d = bitswap16(head[ICAP_DATA_MSB:0]);
        end
    end

    // A dropped push beats a simultaneous clear so software never misses it.
    always_comb begin
        ovf_d = ovf_q;
        if (cmd_stb && full) ovf_d = 1'b1;
        else if (ovf_clr)    ovf_d = 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            clk_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
            ce_n_q  <= ce_n_d;
            wr_n_q  <= wr_n_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cmd_ready    = !full;
    assign busy         = (state_q != ST_IDLE) || !empty;
    assign overflow     = ovf_q;
    assign icap_clk     = clk_q;
    assign icap_ce_n    = ce_n_q;
    assign icap_write_n = wr_n_q;
    assign icap_i       = data_q;

endmodule

// File: tb/tb_icap_ctl.sv
// Bench for icap_ctl: two instances (DEPTH=4/CLKDIV=4 and DEPTH=2/CLKDIV=1) share
// stimulus and are checked every cycle against a queue-based timeline model.
`timescale 1ns/1ps
module tb_icap_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_stb = 1'b0;
    logic [17:0] cmd_data = '0;
    logic        ovf_clr = 1'b0;

    logic        rdy1, busy1, ovf1, clk1, ce1, wr1;
    logic [15:0] i1;
    logic        rdy2, busy2, ovf2, clk2, ce2, wr2;
    logic [15:0] i2;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    icap_ctl #(.DEPTH(4), .CLKDIV(4)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .cmd_stb(cmd_stb), .cmd_data(cmd_data),
        .cmd_ready(rdy1), .busy(busy1), .ovf_clr(ovf_clr), .overflow(ovf1),
        .icap_clk(clk1), .icap_ce_n(ce1), .icap_write_n(wr1), .icap_i(i1)
    );

    icap_ctl #(.DEPTH(2), .CLKDIV(1)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .cmd_stb(cmd_stb), .cmd_data(cmd_data),
        .cmd_ready(rdy2), .busy(busy2), .ovf_clr(ovf_clr), .overflow(ovf2),
        .icap_clk(clk2), .icap_ce_n(ce2), .icap_write_n(wr2), .icap_i(i2)
    );

    // Reference model: pending queue plus the word in flight and its age in cycles.
    logic [17:0] q0[$];
    logic [17:0] q1[$];
    bit          act[2];
    int          age[2];
    bit          mov[2];
    logic [17:0] mw[2];

    logic [15:0] rise_i[$];
    logic [1:0]  rise_cw[$];
    logic        prev_clk1 = 1'b0;

    function automatic int mdiv(input int id);
        return (id == 0) ? 4 : 1;
    endfunction

    function automatic int mdep(input int id);
        return (id == 0) ? 4 : 2;
    endfunction

    function automatic int qsz(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [15:0] rev_bytes(input logic [15:0] x);
        logic [15:0] r;
        for (int b = 0; b < 16; b++) r[(b/8)*8 + 7 - (b%8)] = x[b];
        return r;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int id = 0; id < 2; id++) begin
            act[id] = 0; age[id] = 0; mov[id] = 0; mw[id] = 18'h30000;
        end
    endtask

    task automatic model_step(input int id, input bit stb, input logic [17:0] d, input bit clr);
        bit take = 0;
        bit drop;
        if (!act[id]) take = (qsz(id) != 0);
        else if (age[id] == 2*mdiv(id) - 1) begin
            if (qsz(id) != 0) take = 1;
            else act[id] = 0;
        end else age[id]++;
        drop = stb && (qsz(id) == mdep(id));
        if (take) begin
            mw[id]  = (id == 0) ? q0.pop_front() : q1.pop_front();
            act[id] = 1;
            age[id] = 0;
        end
        if (stb && !drop) begin
            if (id == 0) q0.push_back(d); else q1.push_back(d);
        end
        if (drop) mov[id] = 1;
        else if (clr) mov[id] = 0;
    endtask

    function automatic logic [21:0] mexp(input int id);
        return {act[id] && (age[id] >= mdiv(id)), mw[id][16], mw[id][17], rev_bytes(mw[id][15:0]),
                qsz(id) < mdep(id), act[id] || (qsz(id) != 0), mov[id]};
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk_eq("dut1_outputs", {10'd0, clk1, ce1, wr1, i1, rdy1, busy1, ovf1}, {10'd0, mexp(0)});
        chk_eq("dut2_outputs", {10'd0, clk2, ce2, wr2, i2, rdy2, busy2, ovf2}, {10'd0, mexp(1)});
    endtask

    task automatic cyc(input bit stb, input logic [17:0] d, input bit clr);
        cmd_stb = stb; cmd_data = d; ovf_clr = clr;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            model_step(0, stb, d, clr);
            model_step(1, stb, d, clr);
        end
        #1;
        chk_all();
        if (!prev_clk1 && clk1) begin
            rise_i.push_back(i1);
            rise_cw.push_back({ce1, wr1});
        end
        prev_clk1 = clk1;
        cmd_stb = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300; k++) begin
            if (!busy1 && !busy2) return;
            cyc(0, '0, 0);
        end
        chk_eq(tag, {30'd0, busy1, busy2}, 32'd0);
    endtask

    localparam logic [17:0] SYNC_W [7] = '{18'h3ffff, 18'h0aa99, 18'h05566, 18'h030a1,
                                           18'h00000, 18'h030a1, 18'h0000e};
    localparam logic [15:0] SYNC_I [7] = '{16'hffff, 16'h5599, 16'haa66, 16'h0c85,
                                           16'h0000, 16'h0c85, 16'h0070};

    initial begin
        int fall_at;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all();
        rst_n = 1'b1;
        repeat (2) cyc(0, '0, 0);

        // Sync sequence, one push every 10 cycles.
        rise_i.delete(); rise_cw.delete();
        for (int w = 0; w < 7; w++) begin
            cyc(1, SYNC_W[w], 0);
            repeat (9) cyc(0, '0, 0);
        end
        wait_idle("sync_idle");
        chk_eq("sync_rises", rise_i.size(), 7);
        for (int w = 0; w < 7 && w < rise_i.size(); w++) begin
            chk_eq($sformatf("sync_i%0d", w), {16'd0, rise_i[w]}, {16'd0, SYNC_I[w]});
            chk_eq($sformatf("sync_cw%0d", w), {30'd0, rise_cw[w]}, (w == 0) ? 32'd3 : 32'd0);
        end

        // Latency of a single word from idle.
        repeat (3) cyc(0, '0, 0);
        cyc(1, 18'h02000, 0);
        chk_eq("lat_busy_e0", {31'd0, busy1}, 32'd1);
        cyc(0, '0, 0);
        chk_eq("lat_icap_i_e1", {16'd0, i1}, 32'h0400);
        chk_eq("lat_clk_e1", {31'd0, clk1}, 32'd0);
        for (int e = 2; e <= 10; e++) begin
            cyc(0, '0, 0);
            chk_eq($sformatf("lat_clk_e%0d", e), {31'd0, clk1}, {31'd0, (e >= 5 && e <= 8)});
        end
        chk_eq("lat_busy_e10", {31'd0, busy1}, 32'd0);
        wait_idle("lat_idle");

        // Overflow: six consecutive pushes into DEPTH=4.
        for (int k = 0; k < 6; k++) begin
            cyc(1, 18'($urandom), 0);
            if (k == 4) chk_eq("ovf_ready_full", {31'd0, rdy1}, 32'd0);
        end
        chk_eq("ovf_set", {31'd0, ovf1}, 32'd1);
        fall_at = -1;
        for (int e = 6; e < 100; e++) begin
            cyc(0, '0, 0);
            if (!busy1) begin fall_at = e; break; end
        end
        chk_eq("ovf_five_words_span", fall_at, 41);
        cyc(0, '0, 1);
        chk_eq("ovf_clr", {31'd0, ovf1}, 32'd0);
        wait_idle("ovf_idle");

        // Push while full in the pop cycle, then clear racing a drop.
        for (int k = 0; k < 5; k++) cyc(1, 18'($urandom), 0);
        repeat (4) cyc(0, '0, 0);
        cyc(1, 18'h12345, 0);
        chk_eq("sim_drop_on_pop", {31'd0, ovf1}, 32'd1);
        cyc(0, '0, 1);
        chk_eq("sim_clr", {31'd0, ovf1}, 32'd0);
        cyc(1, 18'h00001, 0);
        cyc(1, 18'h00002, 1);
        chk_eq("sim_set_beats_clr", {31'd0, ovf1}, 32'd1);
        wait_idle("sim_idle");
        cyc(0, '0, 1);

        // Reset during HIGH of the second of three words.
        for (int k = 0; k < 3; k++) cyc(1, 18'h0f0f0 + 18'(k), 0);
        repeat (12) cyc(0, '0, 0);
        chk_eq("rst_pre_high", {31'd0, clk1}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        chk_eq("rst_now", {13'd0, clk1, ce1, wr1, i1, busy1}, {13'd0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0});
        repeat (2) cyc(0, '0, 0);
        rst_n = 1'b1;
        rise_i.delete();
        repeat (30) cyc(0, '0, 0);
        chk_eq("rst_no_stale", rise_i.size(), 0);

        // Back-to-back pushes for the CLKDIV=1 / DEPTH=2 instance.
        for (int k = 0; k < 3; k++) begin
            cyc(1, 18'h31111, 0);
            if (k == 2) chk_eq("div1_high_e2", {15'd0, clk2, i2}, {15'd0, 1'b1, 16'h8888});
        end
        cyc(0, '0, 0);
        chk_eq("div1_low_e3", {31'd0, clk2}, 32'd0);
        wait_idle("div1_idle");
        cyc(0, '0, 1);

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++)
            cyc($urandom_range(0, 2) == 0, 18'($urandom), $urandom_range(0, 15) == 0);
        wait_idle("rand_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
